id_ex_stage: RTL and testbench

- ID/EX pipeline register with integrated load-use hazard detection and write-back bypass.
- Sits between the decode stage and the execute stage, directly upstream of the forwarding unit.
- Supplies the forwarding unit with the registered RS/RT addresses and data.
- Inserts a bubble on a load-use hazard or a branch flush, and freezes on a downstream memory stall.
- Counts inserted bubbles for performance monitoring.

---
 rtl/id_ex_stage.sv | 122 ++++++++++++
 tb/tb_id_ex_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for a five-stage pipeline.
// Detects load-use hazards and inserts bubbles on a hazard or a branch flush.
// Freezes on a downstream memory stall.
// Bypasses the write-back result into the captured operands.
// Counts inserted bubbles with a saturating counter.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] IF_ID_RSaddr_i,
    input  logic [ADDR_W-1:0] IF_ID_RTaddr_i,
    input  logic [ADDR_W-1:0] IF_ID_RDaddr_i,
    input  logic [DATA_W-1:0] RSdata_i,
    input  logic [DATA_W-1:0] RTdata_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [1:0]        WB_i,
    input  logic [1:0]        M_i,
    input  logic [3:0]        EX_i,
    input  logic              MEM_WB_RegWrite_i,
    input  logic [ADDR_W-1:0] MEM_WB_RegDst_i,
    input  logic [DATA_W-1:0] MEM_WB_data_i,
    input  logic              flush_i,
    input  logic              stall_i,
    output logic [ADDR_W-1:0] ID_EX_RSaddr_o,
    output logic [ADDR_W-1:0] ID_EX_RTaddr_o,
    output logic [ADDR_W-1:0] ID_EX_RDaddr_o,
    output logic [DATA_W-1:0] ID_EX_RSdata_o,
    output logic [DATA_W-1:0] ID_EX_RTdata_o,
    output logic [DATA_W-1:0] ID_EX_imm_o,
    output logic [1:0]        ID_EX_WB_o,
    output logic [1:0]        ID_EX_M_o,
    output logic [3:0]        ID_EX_EX_o,
    output logic              ID_EX_valid_o,
    output logic              hazard_o,
    output logic              PC_write_o,
    output logic              IF_ID_write_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    logic              bubble;
    logic              rs_bypass;
    logic              rt_bypass;
    logic [DATA_W-1:0] rs_next;
    logic [DATA_W-1:0] rt_next;

    // A load in EX whose rt is read by decode cannot forward in time, so decode must wait.
    assign hazard_o = ID_EX_valid_o & ID_EX_M_o[1] & (ID_EX_RTaddr_o != '0) &
                      ((ID_EX_RTaddr_o == IF_ID_RSaddr_i) | (ID_EX_RTaddr_o == IF_ID_RTaddr_i));

    // The front end advances unless a hazard or a memory stall holds it.
    // The registered state is meaningless during reset, so the enables are forced high.
    assign PC_write_o    = rst_i | ~(hazard_o | stall_i);
    assign IF_ID_write_o = rst_i | ~(hazard_o | stall_i);

    // A flush and a hazard in the same cycle still produce a single bubble.
    assign bubble = flush_i | hazard_o;

    // The register file is written in the same cycle it is read.
    // Take the write-back value directly so that decode does not see stale data.
    // Register 0 is hard-wired to zero and is never bypassed.
    assign rs_bypass = MEM_WB_RegWrite_i & (MEM_WB_RegDst_i != '0) &
                       (MEM_WB_RegDst_i == IF_ID_RSaddr_i);
    assign rt_bypass = MEM_WB_RegWrite_i & (MEM_WB_RegDst_i != '0) &
                       (MEM_WB_RegDst_i == IF_ID_RTaddr_i);

    // Select the operand values to capture, with write-back taking precedence.
    always_comb begin
        // NOTE: defaults first so that every path assigns every output and no latch is inferred.
        rs_next = RSdata_i;
        rt_next = RTdata_i;
        if (rs_bypass) rs_next = MEM_WB_data_i;
        if (rt_bypass) rt_next = MEM_WB_data_i;
    end

    // Pipeline register with priority reset > stall > bubble > load.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst_i) begin
            ID_EX_RSaddr_o <= '0;
            ID_EX_RTaddr_o <= '0;
            ID_EX_RDaddr_o <= '0;
            ID_EX_RSdata_o <= '0;
            ID_EX_RTdata_o <= '0;
            ID_EX_imm_o    <= '0;
            ID_EX_WB_o     <= '0;
            ID_EX_M_o      <= '0;
            ID_EX_EX_o     <= '0;
            ID_EX_valid_o  <= 1'b0;
            bubble_cnt_o   <= '0;
        end else if (stall_i) begin
            // Hold every register, including the counter.
        end else if (bubble) begin
            // Zero addresses as well so the forwarding unit cannot match a bubble.
            ID_EX_RSaddr_o <= '0;
            ID_EX_RTaddr_o <= '0;
            ID_EX_RDaddr_o <= '0;
            ID_EX_RSdata_o <= '0;
            ID_EX_RTdata_o <= '0;
            ID_EX_imm_o    <= '0;
            ID_EX_WB_o     <= '0;
            ID_EX_M_o      <= '0;
            ID_EX_EX_o     <= '0;
            ID_EX_valid_o  <= 1'b0;
            if (~&bubble_cnt_o) bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
        end else begin
            ID_EX_RSaddr_o <= IF_ID_RSaddr_i;
            ID_EX_RTaddr_o <= IF_ID_RTaddr_i;
            ID_EX_RDaddr_o <= IF_ID_RDaddr_i;
            ID_EX_RSdata_o <= rs_next;
            ID_EX_RTdata_o <= rt_next;
            ID_EX_imm_o    <= imm_i;
            ID_EX_WB_o     <= WB_i;
            ID_EX_M_o      <= M_i;
            ID_EX_EX_o     <= EX_i;
            ID_EX_valid_o  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage.
// Two instances share the stimulus: the default configuration, and one with a 2-bit counter.
// A behavioural model tracks the expected pipeline slot and bubble count.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs_a, rt_a, rd_a, mw_dst;
    logic [31:0] rs_d, rt_d, imm, mw_data;
    logic [1:0]  wb, m;
    logic [3:0]  ex;
    logic        mw_we, flush, stall;

    logic [4:0]  o_rs_a, o_rt_a, o_rd_a;
    logic [31:0] o_rs_d, o_rt_d, o_imm;
    logic [1:0]  o_wb, o_m;
    logic [3:0]  o_ex;
    logic        o_valid, o_haz, o_pcw, o_ifw;
    logic [15:0] o_cnt;

    logic [4:0]  d2_rs_a, d2_rt_a, d2_rd_a;
    logic [31:0] d2_rs_d, d2_rt_d, d2_imm;
    logic [1:0]  d2_wb, d2_m;
    logic [3:0]  d2_ex;
    logic        d2_valid, d2_haz, d2_pcw, d2_ifw;
    logic [1:0]  d2_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic        valid;
        logic [4:0]  rs_a, rt_a, rd_a;
        logic [31:0] rs_d, rt_d, imm;
        logic [1:0]  wb, m;
        logic [3:0]  ex;
        int          cnt;
        int          cnt2;
    } slot_t;

    slot_t exp_s;
    int    saved;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk_i(clk), .rst_i(rst),
        .IF_ID_RSaddr_i(rs_a), .IF_ID_RTaddr_i(rt_a), .IF_ID_RDaddr_i(rd_a),
        .RSdata_i(rs_d), .RTdata_i(rt_d), .imm_i(imm),
        .WB_i(wb), .M_i(m), .EX_i(ex),
        .MEM_WB_RegWrite_i(mw_we), .MEM_WB_RegDst_i(mw_dst), .MEM_WB_data_i(mw_data),
        .flush_i(flush), .stall_i(stall),
        .ID_EX_RSaddr_o(o_rs_a), .ID_EX_RTaddr_o(o_rt_a), .ID_EX_RDaddr_o(o_rd_a),
        .ID_EX_RSdata_o(o_rs_d), .ID_EX_RTdata_o(o_rt_d), .ID_EX_imm_o(o_imm),
        .ID_EX_WB_o(o_wb), .ID_EX_M_o(o_m), .ID_EX_EX_o(o_ex), .ID_EX_valid_o(o_valid),
        .hazard_o(o_haz), .PC_write_o(o_pcw), .IF_ID_write_o(o_ifw), .bubble_cnt_o(o_cnt)
    );

    id_ex_stage #(.CNT_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst),
        .IF_ID_RSaddr_i(rs_a), .IF_ID_RTaddr_i(rt_a), .IF_ID_RDaddr_i(rd_a),
        .RSdata_i(rs_d), .RTdata_i(rt_d), .imm_i(imm),
        .WB_i(wb), .M_i(m), .EX_i(ex),
        .MEM_WB_RegWrite_i(mw_we), .MEM_WB_RegDst_i(mw_dst), .MEM_WB_data_i(mw_data),
        .flush_i(flush), .stall_i(stall),
        .ID_EX_RSaddr_o(d2_rs_a), .ID_EX_RTaddr_o(d2_rt_a), .ID_EX_RDaddr_o(d2_rd_a),
        .ID_EX_RSdata_o(d2_rs_d), .ID_EX_RTdata_o(d2_rt_d), .ID_EX_imm_o(d2_imm),
        .ID_EX_WB_o(d2_wb), .ID_EX_M_o(d2_m), .ID_EX_EX_o(d2_ex), .ID_EX_valid_o(d2_valid),
        .hazard_o(d2_haz), .PC_write_o(d2_pcw), .IF_ID_write_o(d2_ifw), .bubble_cnt_o(d2_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // A load in EX stalls decode when decode reads the loaded (nonzero) register.
    function automatic logic model_haz();
        return exp_s.valid && exp_s.m[1] && exp_s.rt_a != 0 &&
               (exp_s.rt_a == rs_a || exp_s.rt_a == rt_a);
    endfunction

    task automatic model_update();
        logic h;
        int   c, c2;
        h = model_haz();
        if (rst) begin
            exp_s = '{default: '0};
        end else if (stall) begin
            // frozen
        end else if (flush || h) begin
            c  = exp_s.cnt;
            c2 = exp_s.cnt2;
            exp_s = '{default: '0};
            exp_s.cnt  = (c  < 65535) ? c + 1  : c;
            exp_s.cnt2 = (c2 < 3)     ? c2 + 1 : c2;
        end else begin
            exp_s.valid = 1'b1;
            exp_s.rs_a  = rs_a;
            exp_s.rt_a  = rt_a;
            exp_s.rd_a  = rd_a;
            exp_s.rs_d  = (mw_we && mw_dst != 0 && mw_dst == rs_a) ? mw_data : rs_d;
            exp_s.rt_d  = (mw_we && mw_dst != 0 && mw_dst == rt_a) ? mw_data : rt_d;
            exp_s.imm   = imm;
            exp_s.wb    = wb;
            exp_s.m     = m;
            exp_s.ex    = ex;
        end
    endtask

    task automatic check_regs();
        chk("rs_addr", o_rs_a, exp_s.rs_a);
        chk("rt_addr", o_rt_a, exp_s.rt_a);
        chk("rd_addr", o_rd_a, exp_s.rd_a);
        chk("rs_data", o_rs_d, exp_s.rs_d);
        chk("rt_data", o_rt_d, exp_s.rt_d);
        chk("imm",     o_imm,  exp_s.imm);
        chk("wb",      o_wb,   exp_s.wb);
        chk("m",       o_m,    exp_s.m);
        chk("ex",      o_ex,   exp_s.ex);
        chk("valid",   o_valid, exp_s.valid);
        chk("cnt",     o_cnt,  exp_s.cnt);
        chk("cnt2",    d2_cnt, exp_s.cnt2);
        chk("valid2",  d2_valid, exp_s.valid);
    endtask

    // Check the combinational outputs, advance one edge, then check the registers.
    task automatic cycle();
        logic h;
        #1;
        h = model_haz();
        if (!rst) chk("hazard", o_haz, h);
        chk("pc_write",    o_pcw, rst ? 1'b1 : !(h || stall));
        chk("if_id_write", o_ifw, rst ? 1'b1 : !(h || stall));
        model_update();
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic clear_in();
        rst = 0; rs_a = 0; rt_a = 0; rd_a = 0; rs_d = 0; rt_d = 0; imm = 0;
        wb = 0; m = 0; ex = 0; mw_we = 0; mw_dst = 0; mw_data = 0; flush = 0; stall = 0;
    endtask

    task automatic rand_in();
        rs_a = 5'($urandom_range(0, 7));
        rt_a = 5'($urandom_range(0, 7));
        rd_a = 5'($urandom);
        rs_d = $urandom; rt_d = $urandom; imm = $urandom;
        wb = 2'($urandom); m = 2'($urandom); ex = 4'($urandom);
        mw_we = 1'($urandom); mw_dst = 5'($urandom_range(0, 7)); mw_data = $urandom;
    endtask

    initial begin
        exp_s = '{default: '0};
        clear_in();
        @(posedge clk);
        #1;

        // Reset with random inputs for two cycles.
        rst = 1; rand_in(); flush = 1; stall = 1; cycle();
        rand_in(); cycle();
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_cnt", o_cnt, 16'd0);

        // Load-use: lw $8, then an add reading $8.
        clear_in(); rs_a = 1; rt_a = 8; m = 2'b10; wb = 2'b11; ex = 4'b1000; cycle();
        clear_in(); rs_a = 8; rt_a = 9; rd_a = 10; wb = 2'b10; ex = 4'b0101; rs_d = 32'h77;
        #1;
        chk("lu_hazard", o_haz, 1'b1);
        chk("lu_pcw", o_pcw, 1'b0);
        cycle();
        chk("lu_bubble_valid", o_valid, 1'b0);
        chk("lu_bubble_cnt", o_cnt, 16'd1);
        #1;
        chk("lu_hazard_clear", o_haz, 1'b0);
        cycle();
        chk("lu_add_valid", o_valid, 1'b1);
        chk("lu_add_rs", o_rs_a, 5'd8);

        // A load targeting register 0 must not create a hazard.
        clear_in(); m = 2'b10; rt_a = 0; cycle();
        clear_in(); rs_a = 0;
        #1;
        chk("r0_no_hazard", o_haz, 1'b0);
        cycle();
        chk("r0_cnt", o_cnt, 16'd1);

        // Write-back bypass, then the same stimulus aimed at register 0.
        clear_in(); rs_a = 5; rt_a = 5; rs_d = 1; rt_d = 1;
        mw_we = 1; mw_dst = 5; mw_data = 32'hDEADBEEF; cycle();
        chk("byp_rs", o_rs_d, 32'hDEADBEEF);
        chk("byp_rt", o_rt_d, 32'hDEADBEEF);
        rs_a = 0; rt_a = 0; mw_dst = 0; cycle();
        chk("byp0_rs", o_rs_d, 32'h1);
        chk("byp0_rt", o_rt_d, 32'h1);

        // A three-cycle stall with changing inputs and a pending flush.
        clear_in(); rs_a = 3; rt_a = 4; rs_d = 11; wb = 2'b10; cycle();
        saved = exp_s.cnt;
        for (int i = 0; i < 3; i++) begin
            rand_in(); stall = 1; flush = 1; cycle();
            chk("stall_rs_d", o_rs_d, 32'd11);
            chk("stall_cnt", o_cnt, 16'(saved));
        end
        clear_in(); rs_a = 3; rt_a = 4; rs_d = 22; cycle();
        chk("stall_rel_valid", o_valid, 1'b1);
        chk("stall_rel_rs_d", o_rs_d, 32'd22);

        // A flush coinciding with a hazard counts as one bubble.
        clear_in(); m = 2'b10; rt_a = 8; cycle();
        saved = exp_s.cnt;
        clear_in(); rs_a = 8; flush = 1;
        #1;
        chk("fh_hazard", o_haz, 1'b1);
        cycle();
        chk("fh_cnt", o_cnt, 16'(saved + 1));

        // Five bubbles after reset saturate the 2-bit counter at 3.
        clear_in(); rst = 1; cycle();
        clear_in(); flush = 1;
        for (int i = 0; i < 5; i++) cycle();
        chk("sat_cnt2", d2_cnt, 2'd3);
        chk("sat_cnt", o_cnt, 16'd5);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rand_in();
            rst   = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 5) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
